crc8_stream_checker: RTL
========================

# crc8_stream_checker

Receive-side CRC-8 checker. Accepts a byte stream of fixed 9-byte frames (8 data bytes MSB-first, then one CRC byte), recomputes the CRC serially one byte per cycle, and presents the 64-bit payload with a pass/fail flag through a single-entry output register. It sits at the far end of a link whose transmit side uses the `CRC_8` parallel generator, and uses the identical polynomial. A correct frame leaves a zero remainder.

## Interface
- `POLY`, default `crc8_pkg::CRC8_POLY`, generator polynomial (implicit x^8), identical to `CRC_8`.
- `CNT_W`, default 16, width of the saturating statistics counters.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_byte` valid.
- `in_ready`  out  1  checker can accept `in_byte`.
- `in_byte`  in  8  stream byte.
- `in_sof`  in  1  qualifies `in_byte` as first byte of a frame.
- `out_valid`  out  1  checked frame available.
- `out_ready`  in  1  downstream accepts frame.
- `out_data`  out  64  payload; byte 0 is in bits [63:56].
- `out_crc_ok`  out  1  1 = remainder zero.
- `frame_count`  out  CNT_W  frames delivered, saturating.
- `err_count`  out  CNT_W  frames delivered with `out_crc_ok=0`, saturating.
- `abort_count`  out  CNT_W  frames aborted by early SOF, saturating.

## Operation
- Handshake: a byte is transferred when `in_valid && in_ready`. A frame leaves when `out_valid && out_ready`. `out_*` are held stable while `out_valid && !out_ready`.
- CRC update per accepted byte, MSB first, 8 unrolled shift steps: `c = {c[6:0],0} ^ (POLY if c[7]^bit)`. Init 0x00, no reflection, no final XOR. All 9 bytes, including the CRC byte, are fed in. `out_crc_ok` = (final remainder == 0).
- FSM states:
  - IDLE: waits for a byte with `in_sof=1`. Non-SOF bytes are accepted and discarded; no counter changes.
  - RECV: byte index 1..8. Data bytes shift into a 64-bit payload register.
- Transitions:
  - IDLE + SOF byte: CRC = update(0, byte), idx = 1, go to RECV.
  - RECV + byte with idx < 8, no SOF: shift in the byte, idx++.
  - RECV + byte with idx == 8 (the CRC byte): load the output register with payload, ok flag and `out_valid=1`. Increment `frame_count`, and `err_count` if not ok. Go to IDLE.
- Early SOF: a byte with `in_sof=1` in RECV at any idx aborts the partial frame and increments `abort_count`. That byte restarts the frame: CRC = update(0, byte), idx = 1, stay in RECV.
- Backpressure: `in_ready=0` only when in RECV, idx == 8, and `out_valid && !out_ready`. Otherwise `in_ready=1`. Bytes 0..7 of the next frame are accepted while the previous result is held.
- Simultaneous events: the output register can be drained and reloaded in the same cycle. If `out_ready=1` on that cycle, `in_ready=1` as well.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values:
  - `in_ready=1`, `out_valid=0`, `out_data=0`, `out_crc_ok=0`.
  - All counters 0, FSM = IDLE, CRC = 0, idx = 0.
- Latency: `out_valid` is asserted the cycle after the CRC byte handshake.
- Throughput: 1 byte per cycle sustained, i.e. 9 cycles per frame with no downstream stall.
- Reset mid-frame discards the partial frame and any unread output. No counter is incremented.
- `in_ready` is combinational from the state and `out_ready`. There is no combinational path from `in_valid` to `in_ready`.

## Structure
- `crc8_pkg` holds:
  - `CRC8_POLY`, shared with `CRC_8`.
  - `FRAME_BYTES = 9`.
  - the FSM state enum.
  - function `crc8_byte_update(crc, byte, poly)`, reused by the bench model.
- No sub-module is needed. The single-entry output register stays inline.

## Test plan
1. Reset, then send 12 34 56 78 90 AB CD EF FA with SOF on the first byte. Expect `out_valid` one cycle after the last byte, `out_data=0x1234567890ABCDEF`, `out_crc_ok=1`, `frame_count=1`, `err_count=0`.
2. Send back-to-back frames FE DC BA 98 76 54 32 10 C9, then 0F 0F 0F 0F 0F 0F 0F 0F C3, with `out_ready=1`. Expect both `out_crc_ok=1` and `in_ready` constantly 1.
3. Send frame 0F×8 followed by 00. Expect `out_crc_ok=0` and `err_count` incremented by 1.
4. Hold `out_ready=0` after frame 1 and stream frame 2. Expect `in_ready=0` only at frame 2's CRC byte and `out_data` held stable. Release `out_ready`: frame 1 drains, then frame 2 appears the next cycle.
5. Assert SOF at idx 5, then send the valid frame 1. Expect `abort_count=1`, a single correct output, and `frame_count=1`.
6. Pulse `rst` at idx 4, then send frame 1. Expect all counters 0 before the frame, a correct output after it, and no spurious `out_valid`.

Source files
------------

// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions for the receive-side frame checker and its bench.
package crc8_pkg;

  // Generator polynomial (implicit x^8), the same one the CRC_8 transmit generator uses.
  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Frame length: 8 payload bytes followed by one CRC byte.
  localparam int FRAME_BYTES = 9;

  typedef enum logic {
    ST_IDLE,
    ST_RECV
  } state_t;

  // One byte of MSB-first serial CRC: init is supplied by the caller, no reflection, no final XOR.
  function automatic logic [7:0] crc8_byte_update(input logic [7:0] crc,
                                                  input logic [7:0] data,
                                                  input logic [7:0] poly);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ data[i]) ? poly : 8'h00);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_stream_checker.sv
// Receive-side CRC-8 checker: collects 9-byte frames, recomputes the CRC one byte
// per cycle and hands payload plus pass/fail through a single-entry output register.
module crc8_stream_checker
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY  = crc8_pkg::CRC8_POLY,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_crc_ok,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] abort_count
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  state_t      state, state_nxt;
  logic [3:0]  idx;
  logic [7:0]  crc;
  logic [7:0]  crc_next;
  logic [63:0] payload;
  logic        take;
  logic        restart;
  logic        shift;
  logic        finish;
  logic        abort;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Only the CRC byte can stall, and only while the previous result is still unread;
  // out_ready=1 frees the register in the same cycle, so it is accepted then.
  assign in_ready = !((state == ST_RECV) && (idx == LAST_IDX) && out_valid && !out_ready);
  assign take     = in_valid && in_ready;

  // A restarting byte seeds the CRC from zero, otherwise the running remainder is extended.
  assign crc_next = crc8_byte_update(restart ? 8'h00 : crc, in_byte, POLY);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-byte control decode; an SOF byte always wins and restarts the frame.
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take && in_sof) begin
          restart   = 1'b1;
          state_nxt = ST_RECV;
        end
      end
      ST_RECV: begin
        if (take) begin
          if (in_sof) begin
            restart = 1'b1;
            abort   = 1'b1;
          end else if (idx == LAST_IDX) begin
            finish    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Frame accumulation: running CRC, byte index and payload shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc     <= 8'h00;
      idx     <= 4'd0;
      payload <= 64'd0;
    end else if (restart) begin
      crc     <= crc_next;
      idx     <= 4'd1;
      payload <= {payload[55:0], in_byte};
    end else if (shift) begin
      crc     <= crc_next;
      idx     <= idx + 4'd1;
      payload <= {payload[55:0], in_byte};
    end else if (finish) begin
      crc     <= 8'h00;
      idx     <= 4'd0;
    end
  end

  // Single-entry output register: a new result may replace the one draining this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= 64'd0;
      out_crc_ok <= 1'b0;
    end else if (finish) begin
      out_valid  <= 1'b1;
      out_data   <= payload;
      out_crc_ok <= (crc_next == 8'h00);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Statistics counters, bumped when a frame completes or is aborted.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      err_count   <= '0;
      abort_count <= '0;
    end else begin
      if (finish) frame_count <= sat_inc(frame_count);
      if (finish && (crc_next != 8'h00)) err_count <= sat_inc(err_count);
      if (abort) abort_count <= sat_inc(abort_count);
    end
  end

endmodule
